// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/host memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    XFER = 2'd2,
    ACK  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: CPU priority, one 4-cycle transaction per grant.
// Define MEM_ARB_FAIRNESS_EN to force a host grant after MAX_WAIT lost rounds.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  state_t state;
  state_t state_nx;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              any_req;
  logic              grant_host;
  logic              grant;

  assign any_req = cpu_req | host_req;
  assign grant   = (state == IDLE) & any_req;

  if (MAX_WAIT < 1) begin : g_max_wait_chk
    $error("MAX_WAIT must be at least 1");
  end

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             host_turn;

  assign host_turn  = (wait_cnt == CNT_W'(MAX_WAIT));
  assign grant_host = host_req & (~cpu_req | host_turn);

  // Counts rounds the host lost to the CPU; saturates at MAX_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (grant) begin
      if (grant_host) begin
        wait_cnt <= '0;
      end else if (host_req && !host_turn) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign grant_host = host_req & ~cpu_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner   <= grant_host ? OWN_HOST : OWN_CPU;
        we_q    <= grant_host ? host_we : cpu_we;
        addr_q  <= grant_host ? host_addr : cpu_addr;
        wdata_q <= grant_host ? host_wdata : cpu_wdata;
      end
      if (state == XFER && !we_q) begin
        rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Strobes and acks decode straight from state so reset drops them at once.
  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    cpu_ack  = 1'b0;
    host_ack = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nx = ADDR;
      end
      ADDR: state_nx = XFER;
      XFER: begin
        mem_rd   = ~we_q;
        mem_wr   = we_q;
        state_nx = ACK;
      end
      ACK: begin
        cpu_ack  = (owner == OWN_CPU);
        host_ack = (owner == OWN_HOST);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          host_req, host_we, host_ack;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          busy, owner;

  int vectors = 0;
  int miscompares = 0;

  bit   [DW-1:0] dev_mem [32];
  bit   [DW-1:0] ref_mem [32];
  logic [DW-1:0] ref_rdata;

  logic          seed_we = 1'b0;
  logic [AW-1:0] seed_addr = '0;
  logic [DW-1:0] seed_data = '0;

  mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  // Behavioural memory device on the arbiter's memory port
  always @(posedge clk) begin
    if (mem_wr) dev_mem[mem_addr] <= mem_wdata;
    else if (seed_we) dev_mem[seed_addr] <= seed_data;
  end
  assign mem_rdata = dev_mem[mem_addr];

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      vectors++;
      if (mem_rd && mem_wr) begin
        miscompares++;
        $display("FAIL strobe_overlap: mem_rd=%b mem_wr=%b, required not both", mem_rd, mem_wr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request and watches it to its ack (lat 0 = no ack in budget).
  task automatic run_txn(input bit host, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat, output int rd_n,
                         output int wr_n, output logic [AW-1:0] s_addr,
                         output logic [DW-1:0] s_data);
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
    lat = 0; rd_n = 0; wr_n = 0; s_addr = '0; s_data = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        s_addr = mem_addr;
        s_data = mem_wdata;
      end
      if (mem_rd) rd_n++;
      if (mem_wr) wr_n++;
      if (host ? host_ack : cpu_ack) begin
        lat = c;
        break;
      end
    end
    cpu_req = 1'b0;
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      seed_we = 1'b1;
      seed_addr = AW'(i);
      seed_data = (i == 10) ? 8'h5C : DW'($urandom);
      ref_mem[i] = seed_data;
    end
    @(negedge clk);
    seed_we = 1'b0;
    ref_rdata = '0;
    vectors++;
    if ({busy, owner, cpu_ack, host_ack} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/owner/acks=%b required 0000", {busy, owner, cpu_ack, host_ack});
    end
    vectors++;
    if ({mem_rd, mem_wr} !== 2'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: rd/wr=%b required 00", {mem_rd, mem_wr});
    end
    vectors++;
    if (rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h required 0", rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_cpu_read();
    int lat, rd_n, wr_n;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    run_txn(1'b0, 1'b0, 5'h0A, 8'h00, lat, rd_n, wr_n, sa, sd);
    ref_rdata = ref_mem[10];
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL cpu_read_latency: got %0d required 3", lat);
    end
    vectors++;
    if (rd_n !== 1 || wr_n !== 0 || sa !== 5'h0A) begin
      miscompares++;
      $display("FAIL cpu_read_strobe: rd=%0d wr=%0d addr=%h required 1 0 0a", rd_n, wr_n, sa);
    end
    vectors++;
    if (rdata !== 8'h5C || owner !== 1'b0 || host_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_read_data: rdata=%h owner=%b host_ack=%b required 5c 0 0", rdata, owner, host_ack);
    end
    @(negedge clk);
    vectors++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0 || rdata !== 8'h5C) begin
      miscompares++;
      $display("FAIL cpu_read_after: ack=%b busy=%b rdata=%h required 0 0 5c", cpu_ack, busy, rdata);
    end
  endtask

  task automatic test_host_write();
    int lat, rd_n, wr_n;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    run_txn(1'b1, 1'b1, 5'h1F, 8'hA5, lat, rd_n, wr_n, sa, sd);
    ref_mem[31] = 8'hA5;
    vectors++;
    if (lat !== 3 || owner !== 1'b1) begin
      miscompares++;
      $display("FAIL host_write_latency: lat=%0d owner=%b required 3 1", lat, owner);
    end
    vectors++;
    if (wr_n !== 1 || rd_n !== 0 || sa !== 5'h1F || sd !== 8'hA5) begin
      miscompares++;
      $display("FAIL host_write_bus: wr=%0d rd=%0d addr=%h data=%h required 1 0 1f a5", wr_n, rd_n, sa, sd);
    end
    vectors++;
    if (rdata !== ref_rdata) begin
      miscompares++;
      $display("FAIL host_write_rdata: rdata=%h required %h", rdata, ref_rdata);
    end
    @(negedge clk);
    run_txn(1'b0, 1'b0, 5'h1F, 8'h00, lat, rd_n, wr_n, sa, sd);
    ref_rdata = ref_mem[31];
    vectors++;
    if (rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL host_write_readback: rdata=%h required a5", rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, rd_n, wr_n;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    bit host, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 40; i++) begin
      host = 1'($urandom);
      we = 1'($urandom);
      a = AW'($urandom);
      d = DW'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(host, we, a, d, lat, rd_n, wr_n, sa, sd);
      if (we) ref_mem[a] = d;
      else ref_rdata = ref_mem[a];
      vectors++;
      if (lat !== 3 || owner !== host) begin
        miscompares++;
        $display("FAIL rand_grant[%0d]: lat=%0d owner=%b required 3 %b", i, lat, owner, host);
      end
      vectors++;
      if (rd_n !== int'(!we) || wr_n !== int'(we) || sa !== a || (we && sd !== d)) begin
        miscompares++;
        $display("FAIL rand_bus[%0d]: rd=%0d wr=%0d addr=%h data=%h required we=%b addr=%h data=%h",
                 i, rd_n, wr_n, sa, sd, we, a, d);
      end
      vectors++;
      if (rdata !== ref_rdata) begin
        miscompares++;
        $display("FAIL rand_rdata[%0d]: rdata=%h required %h", i, rdata, ref_rdata);
      end
      @(negedge clk);
      vectors++;
      if (cpu_ack !== 1'b0 || host_ack !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_ack_pulse[%0d]: acks=%b%b busy=%b required 000", i, cpu_ack, host_ack, busy);
      end
    end
  endtask

  task automatic test_contention();
    bit order [$];
    int at [$];
    bit exp_host;
    logic [AW-1:0] ca, ha;
    ca = AW'($urandom);
    ha = AW'($urandom);
    cpu_req = 1; cpu_we = 0; cpu_addr = ca;
    host_req = 1; host_we = 0; host_addr = ha;
    for (int c = 1; c <= 80 && order.size() < 8; c++) begin
      @(negedge clk);
      if (cpu_ack) begin order.push_back(1'b0); at.push_back(c); end
      if (host_ack) begin order.push_back(1'b1); at.push_back(c); end
    end
    cpu_req = 0;
    host_req = 0;
    vectors++;
    if (order.size() !== 8) begin
      miscompares++;
      $display("FAIL contention_count: %0d grants required 8", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      exp_host = (k % (MW + 1)) == MW;
`else
      exp_host = 1'b0;
`endif
      vectors++;
      if (order[k] !== exp_host) begin
        miscompares++;
        $display("FAIL contention_grant[%0d]: host=%b required %b", k, order[k], exp_host);
      end
      if (k > 0) begin
        vectors++;
        if (at[k] - at[k-1] !== 4) begin
          miscompares++;
          $display("FAIL contention_spacing[%0d]: %0d cycles required 4", k, at[k] - at[k-1]);
        end
      end
    end
    if (order.size() > 0) begin
      ref_rdata = order[order.size()-1] ? ref_mem[ha] : ref_mem[ca];
      vectors++;
      if (rdata !== ref_rdata) begin
        miscompares++;
        $display("FAIL contention_rdata: rdata=%h required %h", rdata, ref_rdata);
      end
    end
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, rd_n, wr_n, acks;
    logic [AW-1:0] sa, a;
    logic [DW-1:0] sd;
    a = AW'($urandom);
    cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = ~ref_mem[a];
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: mem_wr=%b required 1", mem_wr);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (mem_wr !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: mem_wr=%b busy=%b ack=%b required 000", mem_wr, busy, cpu_ack);
    end
    cpu_req = 0;
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = '0;
    vectors++;
    if (rdata !== '0) begin
      miscompares++;
      $display("FAIL midrst_rdata: rdata=%h required 00", rdata);
    end
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_ack || host_ack) acks++;
    end
    vectors++;
    if (acks !== 0) begin
      miscompares++;
      $display("FAIL midrst_noack: %0d acks required 0", acks);
    end
    run_txn(1'b0, 1'b0, a, 8'h00, lat, rd_n, wr_n, sa, sd);
    ref_rdata = ref_mem[a];
    vectors++;
    if (lat !== 3 || rdata !== ref_rdata) begin
      miscompares++;
      $display("FAIL midrst_resume: lat=%0d rdata=%h required 3 %h", lat, rdata, ref_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_early();
    int n_cpu, cpu_at, host_at;
    logic [DW-1:0] r_at_ack;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] d2;
    a1 = AW'($urandom);
    a2 = AW'($urandom);
    d2 = DW'($urandom);
    n_cpu = 0; cpu_at = 0; host_at = 0; r_at_ack = '0;
    cpu_req = 1; cpu_we = 0; cpu_addr = a1;
    @(negedge clk);
    cpu_req = 0;
    host_req = 1; host_we = 1; host_addr = a2; host_wdata = d2;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        n_cpu++;
        cpu_at = c;
        r_at_ack = rdata;
      end
      if (host_ack) begin
        host_at = c;
        break;
      end
    end
    host_req = 0;
    ref_rdata = ref_mem[a1];
    ref_mem[a2] = d2;
    vectors++;
    if (n_cpu !== 1 || cpu_at !== 3) begin
      miscompares++;
      $display("FAIL drop_cpu_ack: count=%0d cycle=%0d required 1 3", n_cpu, cpu_at);
    end
    vectors++;
    if (r_at_ack !== ref_rdata) begin
      miscompares++;
      $display("FAIL drop_cpu_rdata: rdata=%h required %h", r_at_ack, ref_rdata);
    end
    vectors++;
    if (host_at !== 7) begin
      miscompares++;
      $display("FAIL drop_host_after_idle: host ack cycle=%0d required 7", host_at);
    end
    vectors++;
    if (rdata !== ref_rdata) begin
      miscompares++;
      $display("FAIL drop_host_rdata: rdata=%h required %h", rdata, ref_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_host_write();
    test_random();
    test_contention();
    test_reset_mid();
    test_drop_early();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
